sha256_stream_core: RTL and testbench
=====================================

# sha256_stream_core

Parametrised SHA-256 compression engine. It accepts 512-bit message blocks as a valid/ready stream of 32-bit words, chains any number of blocks per message, and returns the 256-bit digest over a valid/ready handshake. It replaces fixed-length, memory-mapped hashers in the bitcoin hashing path, where several instances run in parallel. Throughput is set by a rounds-per-cycle unroll parameter.

## Interface
- ROUNDS_PER_CYCLE, 1, SHA-256 rounds applied per ROUND cycle; legal values 1, 2, 4, 8.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- abort  in  1  synchronous clear; highest priority after reset
- h_in  in  8x32  initial hash value, loaded at the start of a message
- in_valid  in  1  in_data valid
- in_ready  out  1  core accepts a word this cycle
- in_data  in  32  message word, big-endian, word 0 first
- in_first  in  1  sampled with word 0 of a block: 1 loads H from h_in, 0 chains from the current H
- in_last  in  1  sampled with word 15: 1 marks the final block of the message
- digest_valid  out  1  digest is valid
- digest_ready  in  1  consumer accepts the digest
- digest  out  8x32  H0..H7
- busy  out  1  state is not IDLE

## Operation
- States are IDLE, LOAD, ROUND, UPDATE and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: capture word 0 into W[0]; word counter becomes 1.
  - If in_first=1: H<=h_in and a..h<=h_in. Otherwise a..h<=H.
  - Go to LOAD.
- **LOAD**
  - in_ready=1. Capture words 1..15.
  - in_last is latched only on word 15; on any other word it is ignored.
  - After word 15: round counter becomes 0; go to ROUND.
- **ROUND**
  - in_ready=0. Each cycle applies ROUNDS_PER_CYCLE rounds combinationally.
  - The 16-word schedule window shifts left by R words and appends R expanded words.
  - Round t uses K[t] and window head W[t].
  - After 64/R cycles, go to UPDATE.
- **UPDATE** (one cycle): H[i]<=H[i]+{a..h}[i], mod 2^32.
  - If last=1: go to DONE.
  - Otherwise: go to IDLE to take the next block.
- **DONE**
  - digest_valid=1; digest=H, held stable.
  - On digest_ready: go to IDLE.
- All arithmetic is 32-bit modulo; carries are discarded. Rotations are by constant amounts.
- Padding is not done here. Upstream supplies fully padded blocks.
- abort: state<=IDLE, counters<=0, last<=0, digest_valid drops the next cycle. H is not cleared; the next block must carry in_first=1.
- in_first=1 on word 0 of any block discards the chained H and restarts from h_in. This is legal.
- in_valid while in_ready=0 is ignored; no word is consumed.
- digest_ready without digest_valid is ignored.

## Timing
- Reset values:
  - state=IDLE.
  - in_ready=1, combinational from state once reset_n is released.
  - digest_valid=0, busy=0, digest=0 (H=0), counters=0, last=0.
- Reset asserted mid-operation forces all of the above immediately. Any partial block is lost.
- Word 15 accepted at edge T:
  - ROUND occupies T+1..T+64/R.
  - UPDATE occurs at T+64/R+1.
  - digest_valid is high from T+64/R+2, or in_ready is high again at that cycle for a non-final block.
  - R=1: 66 cycles. R=4: 18 cycles.
- Block throughput: 16 + 64/R + 1 cycles at full in_valid.
- Digest backpressure stalls the core in DONE. in_ready stays 0 until the handshake completes.
- abort and in_valid in the same cycle: abort wins; the word is not consumed.

## Structure
- Package sha256_pkg holds:
  - K[0:63] table and SHA-256 IV constants
  - rotr, sigma0/1, Sigma0/1, ch, maj functions
  - sha256_round function returning {a..h}
  - state enum type
- Sub-module sha256_msg_sched:
  - 16x32 window with R-word shift and expansion.
  - Ports: clk, reset_n, load/valid/data, advance, head[R].
- The top holds the FSM, counters, H/a..h registers and an unrolled chain of R sha256_round calls.

## Test plan
- "abc" as one padded block, in_first=1, in_last=1, h_in=IV, R=1 -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with digest_valid exactly 66 cycles after word 15.
- Empty-message padded block (80000000, then 14 zero words, then 00000000) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as 2 blocks, in_first only on block 1, random in_valid gaps -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1. Repeat for R=2, 4 and 8, checking 64/R+2 latency.
- digest_ready held low for 10 cycles after digest_valid -> digest stable, in_ready=0, busy=1; one cycle after the handshake, in_ready=1.
- abort during ROUND cycle 20, then "abc" -> correct "abc" digest. No digest_valid is produced for the aborted message.
- reset_n low during LOAD word 7 -> all outputs at reset values in the same cycle; the following "abc" hash is correct.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round primitives and the FSM state type shared by the
// stream core, its message schedule and the bench.
package sha256_pkg;

  // H0..H7 / a..h, index 0 is H0 (most significant word of the digest).
  typedef logic [0:7][31:0] hash_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_UPDATE,
    ST_DONE
  } state_t;

  localparam hash_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount (1..31).
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Schedule expansion sigmas.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Compression sigmas.
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // One compression round: takes {a..h}, round constant and schedule word.
  function automatic hash_t sha256_round(input hash_t s, input logic [31:0] k,
                                         input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    hash_t r;
    t1 = s[7] + big_sigma1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
    t2 = big_sigma0(s[0]) + maj(s[0], s[1], s[2]);
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// Message-word input stream and digest output stream of the SHA-256 core.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high. The producer holds valid, data and the
// first/last flags stable until that edge; ready may depend combinationally on
// the consumer's state but never on valid.
interface sha256_stream_if;
  import sha256_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_first;
  logic        in_last;

  logic        digest_valid;
  logic        digest_ready;
  hash_t       digest;

  // Producer of message words / consumer of digests.
  modport master (
    output in_valid, in_data, in_first, in_last, digest_ready,
    input  in_ready, digest_valid, digest
  );

  // The hashing core.
  modport slave (
    input  in_valid, in_data, in_first, in_last, digest_ready,
    output in_ready, digest_valid, digest
  );

endinterface

// File: rtl/sha256_msg_sched.sv
// 16-word SHA-256 message schedule window. Words are shifted in one at a time
// during block load; during rounds the window slides by R words per cycle and
// R freshly expanded words are appended. head[j] is W[t+j] for the current t.
module sha256_msg_sched import sha256_pkg::*; #(
  parameter int R = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  advance,
  output logic [0:R-1][31:0]    head
);

  logic [31:0] win      [16];
  logic [31:0] win_next [16];

  // Expand R words beyond the window and expose the R words used this cycle.
  always_comb begin
    logic [31:0] ext [16+R];
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = sigma1(ext[14+j]) + ext[9+j] + sigma0(ext[1+j]) + ext[j];
    end
    for (int i = 0; i < 16; i++) win_next[i] = ext[R+i];
    for (int j = 0; j < R; j++) head[j] = win[j];
  end

  // Window register: shift-in on load, slide by R on advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load_valid) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= load_data;
    end else if (advance) begin
      for (int i = 0; i < 16; i++) win[i] <= win_next[i];
    end
  end

endmodule

// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 compression core. Takes padded 512-bit blocks as 32-bit
// words, chains blocks of one message through H, applies ROUNDS_PER_CYCLE
// rounds per ROUND cycle and presents the digest over a valid/ready handshake.
// ROUNDS_PER_CYCLE must be 1, 2, 4 or 8.
module sha256_stream_core import sha256_pkg::*; #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              abort,
  input  hash_t             h_in,
  sha256_stream_if.slave    bus,
  output logic              busy,
  output state_t            dbg_state
);

  localparam int         R        = ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_RND = 6'(64 - R);

  state_t              state;
  state_t              state_next;
  logic [3:0]          word_cnt;
  logic [5:0]          rnd_cnt;
  logic                last_q;
  hash_t               h_q;
  hash_t               work_q;
  hash_t               work_next;
  logic                accept;
  logic [0:R-1][31:0]  w_head;

  // abort outranks a word offered in the same cycle.
  assign accept      = bus.in_valid && bus.in_ready && !abort;
  assign bus.digest  = h_q;
  assign dbg_state   = state;

  sha256_msg_sched #(.R(R)) u_sched (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (accept),
    .load_data  (bus.in_data),
    .advance    ((state == ST_ROUND) && !abort),
    .head       (w_head)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    state_next       = state;
    bus.in_ready     = 1'b0;
    bus.digest_valid = 1'b0;
    busy             = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (word_cnt == 4'd15)) state_next = ST_ROUND;
      end
      ST_ROUND: begin
        if (rnd_cnt == LAST_RND) state_next = ST_UPDATE;
      end
      ST_UPDATE: begin
        state_next = last_q ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        bus.digest_valid = 1'b1;
        if (bus.digest_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) state_next = ST_IDLE;
  end

  // Unrolled chain of R rounds starting from the working variables.
  always_comb begin
    hash_t      s;
    logic [5:0] t;
    s = work_q;
    t = rnd_cnt;
    for (int j = 0; j < R; j++) begin
      t = rnd_cnt + 6'(j);
      s = sha256_round(s, K[t], w_head[j]);
    end
    work_next = s;
  end

  // Counters, chaining value H and working variables a..h.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt <= '0;
      rnd_cnt  <= '0;
      last_q   <= 1'b0;
      h_q      <= '0;
      work_q   <= '0;
    end else if (abort) begin
      // H is kept; the next block is expected to restart from h_in.
      word_cnt <= '0;
      rnd_cnt  <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            word_cnt <= 4'd1;
            if (bus.in_first) begin
              h_q    <= h_in;
              work_q <= h_in;
            end else begin
              work_q <= h_q;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            word_cnt <= word_cnt + 4'd1;
            if (word_cnt == 4'd15) begin
              last_q  <= bus.in_last;
              rnd_cnt <= '0;
            end
          end
        end
        ST_ROUND: begin
          work_q  <= work_next;
          // Wraps back to 0 after the final round cycle.
          rnd_cnt <= rnd_cnt + 6'(R);
        end
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + work_q[i];
        end
        ST_DONE: begin
          if (bus.digest_ready) last_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: four instances (1, 2, 4, 8 rounds per cycle)
// share the stimulus; only the instance picked by sel sees valid/abort.
module tb_sha256_stream_core;
  import sha256_pkg::*;

  localparam logic [255:0] IV_TB   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_448   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        m_valid = 1'b0;
  logic        m_first = 1'b0;
  logic        m_last = 1'b0;
  logic        m_dready = 1'b1;
  logic        m_abort = 1'b0;
  logic [31:0] m_data = '0;
  hash_t       h_in;

  wire [3:0]   ir;
  wire [3:0]   dv;
  wire [3:0]   bz;
  wire [255:0] dg [4];
  wire [2:0]   st [4];

  assign h_in = IV_TB;

  for (genvar g = 0; g < 4; g++) begin : gen_dut
    sha256_stream_if bus ();
    state_t dbg;
    logic   b;
    assign bus.in_valid     = m_valid && (sel == g);
    assign bus.in_data      = m_data;
    assign bus.in_first     = m_first;
    assign bus.in_last      = m_last;
    assign bus.digest_ready = m_dready;
    sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .abort     (m_abort && (sel == g)),
      .h_in      (h_in),
      .bus       (bus),
      .busy      (b),
      .dbg_state (dbg)
    );
    assign ir[g] = bus.in_ready;
    assign dv[g] = bus.digest_valid;
    assign bz[g] = b;
    assign dg[g] = bus.digest;
    assign st[g] = dbg;
  end

  // ---------------- scoreboard ----------------
  logic [255:0] exp_q [$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [31:0]  blk [16];

  task automatic set_block(input int id);
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    case (id)
      0: begin blk[0] = 32'h61626380; blk[15] = 32'h00000018; end
      1: begin blk[0] = 32'h80000000; end
      2: begin
        blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      end
      default: begin blk[15] = 32'h000001c0; end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic f, input logic l);
    int to;
    m_valid = 1'b1;
    m_data  = d;
    m_first = f;
    m_last  = l;
    for (to = 0; to < 400; to++) begin
      @(negedge clk);
      if (ir[sel]) break;
    end
    if (to >= 400) begin
      n_checks++;
      $display("FAIL send_word: in_ready never high (sel=%0d)", sel);
    end else begin
      @(posedge clk);
      #1;
    end
    m_valid = 1'b0;
  endtask

  // in_first/in_last get random values on the words where they are ignored.
  task automatic send_block(input logic first, input logic last, input int gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) begin @(posedge clk); #1; end
      send_word(blk[i], (i == 0) ? first : 1'($urandom_range(0, 1)),
                (i == 15) ? last : 1'($urandom_range(0, 1)));
    end
  endtask

  // Waits for digest_valid, checks latency (edges after word 15 up to the first
  // edge the digest can be taken; 0 = skip) and the digest, then handshakes.
  task automatic wait_digest(input int exp_lat, input string name);
    int lat;
    logic [255:0] e;
    for (lat = 1; lat <= 300; lat++) begin
      @(posedge clk);
      #1;
      if (dv[sel]) break;
    end
    n_checks++;
    if (!dv[sel]) begin
      $display("FAIL %s: digest_valid timeout", name);
    end else begin
      n_pass++;
      if (exp_lat > 0) begin
        n_checks++;
        if (lat + 1 !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat + 1, exp_lat);
        else n_pass++;
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL %s: unexpected digest %h", name, dg[sel]);
      end else begin
        e = exp_q.pop_front();
        if (dg[sel] !== e) $display("FAIL %s digest: got %h want %h", name, dg[sel], e);
        else n_pass++;
      end
      if (m_dready) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n_checks++;
      if (ir[g] !== 1'b1 || dv[g] !== 1'b0 || bz[g] !== 1'b0)
        $display("FAIL reset flags[%0d]: ready=%b valid=%b busy=%b want 1 0 0", g, ir[g], dv[g], bz[g]);
      else n_pass++;
      n_checks++;
      if (dg[g] !== 256'h0) $display("FAIL reset digest[%0d]: got %h want 0", g, dg[g]);
      else n_pass++;
      n_checks++;
      if (st[g] !== ST_IDLE) $display("FAIL reset state[%0d]: got %0d want %0d", g, st[g], ST_IDLE);
      else n_pass++;
    end
  endtask

  task automatic test_abc();
    sel = 0;
    set_block(0);
    exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 0);
    wait_digest(66, "abc");
  endtask

  task automatic test_empty();
    sel = 0;
    set_block(1);
    exp_q.push_back(D_EMPTY);
    send_block(1'b1, 1'b1, 2);
    wait_digest(66, "empty");
  endtask

  task automatic test_two_block();
    int cnt;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      exp_q.push_back(D_448);
      set_block(2);
      send_block(1'b1, 1'b0, 3);
      for (cnt = 1; cnt <= 300; cnt++) begin
        @(posedge clk);
        #1;
        if (ir[sel]) break;
      end
      n_checks++;
      if (cnt + 1 !== 64 / (1 << s) + 2)
        $display("FAIL two_block ready return R=%0d: got %0d want %0d", 1 << s, cnt + 1, 64 / (1 << s) + 2);
      else n_pass++;
      set_block(3);
      send_block(1'b0, 1'b1, 3);
      wait_digest(64 / (1 << s) + 2, "two_block");
    end
  endtask

  task automatic test_backpressure();
    sel = 0;
    m_dready = 1'b0;
    set_block(0);
    exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 0);
    wait_digest(66, "bp_abc");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (dg[0] !== D_ABC || ir[0] !== 1'b0 || bz[0] !== 1'b1 || dv[0] !== 1'b1)
        $display("FAIL backpressure hold %0d: digest=%h ready=%b busy=%b valid=%b", i, dg[0], ir[0], bz[0], dv[0]);
      else n_pass++;
    end
    m_dready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (ir[0] !== 1'b1 || dv[0] !== 1'b0)
      $display("FAIL backpressure release: ready=%b valid=%b want 1 0", ir[0], dv[0]);
    else n_pass++;
  endtask

  task automatic test_abort();
    int hits;
    sel = 0;
    set_block(0);
    send_block(1'b1, 1'b1, 0);
    repeat (20) begin @(posedge clk); #1; end
    n_checks++;
    if (st[0] !== ST_ROUND) $display("FAIL abort pre-state: got %0d want %0d", st[0], ST_ROUND);
    else n_pass++;
    m_abort = 1'b1;
    @(posedge clk);
    #1;
    m_abort = 1'b0;
    n_checks++;
    if (st[0] !== ST_IDLE || bz[0] !== 1'b0 || dv[0] !== 1'b0)
      $display("FAIL abort state: state=%0d busy=%b valid=%b", st[0], bz[0], dv[0]);
    else n_pass++;
    // abort together with a valid word: the word must not be taken
    m_abort = 1'b1;
    m_valid = 1'b1;
    m_first = 1'b1;
    m_data  = 32'hdeadbeef;
    @(posedge clk);
    #1;
    m_abort = 1'b0;
    m_valid = 1'b0;
    n_checks++;
    if (st[0] !== ST_IDLE) $display("FAIL abort+valid: state=%0d want %0d", st[0], ST_IDLE);
    else n_pass++;
    hits = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (dv[0]) hits++;
    end
    n_checks++;
    if (hits !== 0) $display("FAIL abort no-digest: digest_valid seen %0d cycles want 0", hits);
    else n_pass++;
    exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 1);
    wait_digest(66, "abort_then_abc");
  endtask

  task automatic test_reset_mid();
    sel = 0;
    set_block(0);
    for (int i = 0; i < 7; i++) send_word(blk[i], (i == 0), 1'b0);
    n_checks++;
    if (dg[0] !== IV_TB) $display("FAIL h loaded from h_in: got %h want %h", dg[0], IV_TB);
    else n_pass++;
    m_valid = 1'b1;
    m_data  = blk[7];
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (ir[0] !== 1'b1 || dv[0] !== 1'b0 || bz[0] !== 1'b0 || dg[0] !== 256'h0 || st[0] !== ST_IDLE)
      $display("FAIL reset mid-load: ready=%b valid=%b busy=%b state=%0d digest=%h", ir[0], dv[0], bz[0], st[0], dg[0]);
    else n_pass++;
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q.push_back(D_ABC);
    send_block(1'b1, 1'b1, 0);
    wait_digest(66, "reset_then_abc");
  endtask

  task automatic test_back_to_back();
    sel = 2;
    exp_q.push_back(D_ABC);
    exp_q.push_back(D_EMPTY);
    fork
      begin
        set_block(0);
        send_block(1'b1, 1'b1, 0);
        set_block(1);
        send_block(1'b1, 1'b1, 0);
      end
      begin
        wait_digest(0, "b2b_first");
        wait_digest(0, "b2b_second");
      end
    join
    n_checks++;
    if (exp_q.size() !== 0) $display("FAIL b2b leftover expected: %0d entries", exp_q.size());
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_abc();
    test_empty();
    test_two_block();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
